im_fetch_ctrl: RTL and testbench

- Fetch-stage sequencer for the 4K-word instruction memory.
- Owns the architectural PC and drives the IM address.
- Arbitrates next-PC sources (reset, exception, eret, branch, sequential) and buffers a branch redirect that arrives during a stall.
- Checks fetch addresses and replaces bad fetches with NOP plus an AdEL indication; sits between the hazard/CP0 logic and the IM.

---
 rtl/im_fetch_ctrl.sv | 96 +++++++++
 tb/tb_im_fetch_ctrl.sv | 135 +++++++++++++
 2 files changed

// File: rtl/im_fetch_ctrl.sv
// im_fetch_ctrl: fetch-stage PC sequencer with redirect buffering and AdEL fetch checking.
// Optional FETCH_PERF_CNT_EN adds perf_fetch/perf_stall counters.
module im_fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter int          IM_WORDS   = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        br_take,
  input  logic [31:0] br_target,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] epc,
  input  logic [31:0] instr_in,
  output logic [31:0] im_addr,
  output logic [31:0] pc_out,
  output logic [31:0] instr_out,
  output logic        fetch_valid,
  output logic        fetch_exc,
  output logic [4:0]  fetch_exccode
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch,
  output logic [31:0] perf_stall
`endif
);
  typedef enum logic {BOOT, RUN} state_t;
  localparam logic [31:0] LAST_PC = RESET_PC + 32'(4 * IM_WORDS) - 32'd4;
  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt, r_pend_pc, w_pend_pc_nxt;
  logic        r_pend_v, w_pend_v_nxt;
  logic        w_run, w_illegal;
  assign w_run     = r_state == RUN;
  assign w_illegal = (r_pc[1:0] != 2'b00) || (r_pc < RESET_PC) || (r_pc > LAST_PC);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state   <= BOOT;
      r_pc      <= RESET_PC;
      r_pend_v  <= 1'b0;
      r_pend_pc <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_pend_v  <= w_pend_v_nxt;
      r_pend_pc <= w_pend_pc_nxt;
    end
  // Flushes (exception, eret) beat stall; a redirect seen during stall waits in pend.
  always_comb begin
    w_state_nxt   = RUN;
    w_pc_nxt      = r_pc;
    w_pend_v_nxt  = r_pend_v;
    w_pend_pc_nxt = r_pend_pc;
    if (w_run) begin
      if (exc_req) begin
        w_pc_nxt     = HANDLER_PC;
        w_pend_v_nxt = 1'b0;
      end else if (eret_req) begin
        w_pc_nxt     = epc;
        w_pend_v_nxt = 1'b0;
      end else if (stall) begin
        w_pend_v_nxt  = r_pend_v | br_take;
        w_pend_pc_nxt = br_take ? br_target : r_pend_pc;
      end else if (br_take) begin
        w_pc_nxt     = br_target;
        w_pend_v_nxt = 1'b0;
      end else if (r_pend_v) begin
        w_pc_nxt     = r_pend_pc;
        w_pend_v_nxt = 1'b0;
      end else
        w_pc_nxt = r_pc + 32'd4;
    end
  end
  always_comb begin
    im_addr       = r_pc;
    pc_out        = r_pc;
    fetch_valid   = w_run & ~w_illegal;
    fetch_exc     = w_run & w_illegal;
    fetch_exccode = fetch_exc ? 5'd4 : 5'd0;
    instr_out     = fetch_valid ? instr_in : 32'd0;
  end
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_perf_fetch, r_perf_stall;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_perf_fetch <= '0;
      r_perf_stall <= '0;
    end else if (w_run) begin
      r_perf_fetch <= r_perf_fetch + 32'(fetch_valid & ~stall);
      r_perf_stall <= r_perf_stall + 32'(stall);
    end
  assign perf_fetch = r_perf_fetch;
  assign perf_stall = r_perf_stall;
`endif
endmodule

// File: tb/tb_im_fetch_ctrl.sv
// tb_im_fetch_ctrl: directed stimulus, cycle-by-cycle reference model plus literal checkpoints.
module tb_im_fetch_ctrl;
  localparam logic [31:0] K = 32'hA5A5_0000;
  logic        clk = 1'b0;
  logic        reset, stall, br_take, exc_req, eret_req;
  logic [31:0] br_target, epc, instr_in;
  logic [31:0] im_addr, pc_out, instr_out;
  logic        fetch_valid, fetch_exc;
  logic [4:0]  fetch_exccode;
  int          n_chk = 0, n_fail = 0;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch, perf_stall;
`endif
  im_fetch_ctrl dut (
    .clk(clk), .reset(reset), .stall(stall), .br_take(br_take), .br_target(br_target),
    .exc_req(exc_req), .eret_req(eret_req), .epc(epc), .instr_in(instr_in),
    .im_addr(im_addr), .pc_out(pc_out), .instr_out(instr_out), .fetch_valid(fetch_valid),
    .fetch_exc(fetch_exc), .fetch_exccode(fetch_exccode)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetch(perf_fetch), .perf_stall(perf_stall)
`endif
  );
  always #5 clk = ~clk;
  assign instr_in = im_addr ^ K;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask
  function automatic bit legal(input logic [31:0] p);
    return p[1:0] == 2'b00 && p >= 32'h3000 && p <= 32'h3000 + 4 * 4096 - 4;
  endfunction
  logic        m_boot, m_pv;
  logic [31:0] m_pc, m_pp, m_pf, m_ps;
  always @(posedge clk or posedge reset)
    if (reset) begin
      m_boot <= 1'b1; m_pc <= 32'h3000; m_pv <= 1'b0; m_pp <= '0; m_pf <= '0; m_ps <= '0;
    end else begin
      m_boot <= 1'b0;
      if (!m_boot) begin
        if (legal(m_pc) && !stall) m_pf <= m_pf + 1;
        if (stall) m_ps <= m_ps + 1;
        if (exc_req) begin m_pc <= 32'h4180; m_pv <= 1'b0; end
        else if (eret_req) begin m_pc <= epc; m_pv <= 1'b0; end
        else if (stall) begin if (br_take) begin m_pv <= 1'b1; m_pp <= br_target; end end
        else if (br_take) begin m_pc <= br_target; m_pv <= 1'b0; end
        else if (m_pv) begin m_pc <= m_pp; m_pv <= 1'b0; end
        else m_pc <= m_pc + 4;
      end
    end
  always @(negedge clk)
    if (!reset) begin
      chk("m_pc_out", pc_out, m_pc);
      chk("m_im_addr", im_addr, m_pc);
      chk("m_valid", 32'(fetch_valid), 32'(!m_boot && legal(m_pc)));
      chk("m_exc", 32'(fetch_exc), 32'(!m_boot && !legal(m_pc)));
      chk("m_code", 32'(fetch_exccode), (!m_boot && !legal(m_pc)) ? 32'd4 : 32'd0);
      chk("m_instr", instr_out, (!m_boot && legal(m_pc)) ? (m_pc ^ K) : 32'd0);
`ifdef FETCH_PERF_CNT_EN
      chk("m_perf_fetch", perf_fetch, m_pf);
      chk("m_perf_stall", perf_stall, m_ps);
`endif
    end
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask
  task automatic flags(input string n, input logic [31:0] pc, input bit v);
    chk({n, "_pc"}, pc_out, pc);
    chk({n, "_valid"}, 32'(fetch_valid), 32'(v));
    chk({n, "_exc"}, 32'(fetch_exc), 32'(!v));
    chk({n, "_code"}, 32'(fetch_exccode), v ? 32'd0 : 32'd4);
    chk({n, "_instr"}, instr_out, v ? (pc ^ K) : 32'd0);
  endtask
  initial begin
    reset = 1'b1; stall = 0; br_take = 0; exc_req = 0; eret_req = 0; br_target = 0; epc = 0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    chk("boot_pc", pc_out, 32'h3000);
    chk("boot_valid", 32'(fetch_valid), 32'd0);
    chk("boot_instr", instr_out, 32'd0);
    cyc(); flags("run0", 32'h3000, 1);
    cyc(); flags("run1", 32'h3004, 1);
    cyc(); flags("run2", 32'h3008, 1);
    cyc(); cyc(); chk("at3010", pc_out, 32'h3010);
    stall = 1; br_take = 1; br_target = 32'h3100;
    cyc(); chk("stall1", pc_out, 32'h3010);
    br_take = 0;
    cyc(); chk("stall2", pc_out, 32'h3010);
    cyc(); chk("stall3", pc_out, 32'h3010);
    stall = 0;
    cyc(); chk("pend_jump", pc_out, 32'h3100);
`ifdef FETCH_PERF_CNT_EN
    chk("perf_fetch5", perf_fetch, 32'd5);
    chk("perf_stall3", perf_stall, 32'd3);
`endif
    cyc(); chk("after_jump", pc_out, 32'h3104);
    br_take = 1; br_target = 32'h3020;
    cyc(); br_take = 0; chk("at3020", pc_out, 32'h3020);
    stall = 1; br_take = 1; br_target = 32'h3200; exc_req = 1;
    cyc(); stall = 0; br_take = 0; exc_req = 0; flags("exc", 32'h4180, 1);
    cyc(); chk("h1", pc_out, 32'h4184);
    cyc(); chk("h2", pc_out, 32'h4188);
    eret_req = 1; epc = 32'h3024;
    cyc(); eret_req = 0; flags("eret", 32'h3024, 1);
    br_take = 1; br_target = 32'h3002;
    cyc(); br_take = 0; flags("misalign", 32'h3002, 0);
    cyc(); flags("misalign_seq", 32'h3006, 0);
    br_take = 1; br_target = 32'h7000;
    cyc(); br_take = 0; flags("over", 32'h7000, 0);
    exc_req = 1;
    cyc(); exc_req = 0; flags("exc_clear", 32'h4180, 1);
    br_take = 1; br_target = 32'h6FFC;
    cyc(); br_take = 0; flags("last", 32'h6FFC, 1);
    cyc(); flags("past_last", 32'h7000, 0);
    br_take = 1; br_target = 32'h2FFC;
    cyc(); br_take = 0; flags("under", 32'h2FFC, 0);
    cyc(); flags("first", 32'h3000, 1);
    stall = 1; br_take = 1; br_target = 32'h3300;
    cyc(); br_take = 0;
    #1 reset = 1'b1;
    #1 chk("async_pc", pc_out, 32'h3000);
    chk("async_valid", 32'(fetch_valid), 32'd0);
    @(posedge clk);
    #2 reset = 1'b0; stall = 0;
    chk("boot2_valid", 32'(fetch_valid), 32'd0);
    cyc(); chk("rel0", pc_out, 32'h3000);
    cyc(); chk("rel1_nopend", pc_out, 32'h3004);
    cyc(); cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
